// File: rtl/flag_register_unit.sv
// Flag pipeline from EX to commit, with the architectural flag register and an interrupt shadow copy.
// Commit latency is COMMIT_DEPTH edges. A stall freezes the pipe and drops the input. Forwarding and the condition are combinational.
module flag_register_unit #(
  parameter int FLAG_W       = 4,
  parameter int COMMIT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLAG_W-1:0] flag_set_input,
  input  logic              flag_write_en,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              stall,
  input  logic              flush,
  input  logic              irq_save,
  input  logic              irq_restore,
  input  logic [2:0]        cond_code,
  output logic [FLAG_W-1:0] flags_committed,
  output logic [FLAG_W-1:0] flags_forwarded,
  output logic              cond_true,
  output logic              flags_pending
);

  localparam int Z_B = FLAG_W - 1;
  localparam int S_B = FLAG_W - 2;
  localparam int C_B = FLAG_W - 3;
  localparam int V_B = FLAG_W - 4;
  localparam int OLD = COMMIT_DEPTH - 1;

  logic              ent_vld  [COMMIT_DEPTH];
  logic [FLAG_W-1:0] ent_mask [COMMIT_DEPTH];
  logic [FLAG_W-1:0] ent_dat  [COMMIT_DEPTH];
  logic [FLAG_W-1:0] committed_q;
  logic [FLAG_W-1:0] shadow_q;
  logic [FLAG_W-1:0] commit_val;
  logic [FLAG_W-1:0] fwd;
  logic              commit_fire;

  // Flush does not block the commit of the oldest entry; only stall does.
  assign commit_fire = ent_vld[OLD] & ~stall;

  always_comb begin
    commit_val = committed_q;
    if (commit_fire) begin
      commit_val = (committed_q & ~ent_mask[OLD]) | (ent_dat[OLD] & ent_mask[OLD]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < COMMIT_DEPTH; i++) begin
        ent_vld[i]  <= 1'b0;
        ent_mask[i] <= '0;
        ent_dat[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < COMMIT_DEPTH; i++) begin
        ent_vld[i] <= 1'b0;
      end
    end else if (!stall) begin
      ent_vld[0]  <= flag_write_en;
      ent_mask[0] <= flag_mask;
      ent_dat[0]  <= flag_set_input;
      for (int i = 1; i < COMMIT_DEPTH; i++) begin
        ent_vld[i]  <= ent_vld[i-1];
        ent_mask[i] <= ent_mask[i-1];
        ent_dat[i]  <= ent_dat[i-1];
      end
    end
  end

  // Restore beats both a same-edge commit and a same-edge save.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      committed_q <= '0;
      shadow_q    <= '0;
    end else if (irq_restore) begin
      committed_q <= shadow_q;
    end else begin
      committed_q <= commit_val;
      if (irq_save) begin
        shadow_q <= commit_val;
      end
    end
  end

  always_comb begin
    fwd = committed_q;
    for (int i = OLD; i >= 0; i--) begin
      if (ent_vld[i]) begin
        fwd = (fwd & ~ent_mask[i]) | (ent_dat[i] & ent_mask[i]);
      end
    end
    if (flag_write_en && !flush) begin
      fwd = (fwd & ~flag_mask) | (flag_set_input & flag_mask);
    end
  end

  always_comb begin
    case (cond_code)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = fwd[Z_B];
      3'd2:    cond_true = ~fwd[Z_B];
      3'd3:    cond_true = fwd[S_B];
      3'd4:    cond_true = ~fwd[S_B];
      3'd5:    cond_true = fwd[C_B];
      3'd6:    cond_true = fwd[V_B];
      default: cond_true = fwd[S_B] ^ fwd[V_B];
    endcase
  end

  always_comb begin
    flags_pending = 1'b0;
    for (int i = 0; i < COMMIT_DEPTH; i++) begin
      flags_pending = flags_pending | ent_vld[i];
    end
  end

  assign flags_committed = committed_q;
  assign flags_forwarded = fwd;

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed vector table, reset-mid-operation sequence, random run against a queue-based model.
module tb_flag_register_unit;

  localparam int FW = 4;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [FW-1:0] flag_set_input;
  logic          flag_write_en;
  logic [FW-1:0] flag_mask;
  logic          stall;
  logic          flush;
  logic          irq_save;
  logic          irq_restore;
  logic [2:0]    cond_code;
  logic [FW-1:0] flags_committed;
  logic [FW-1:0] flags_forwarded;
  logic          cond_true;
  logic          flags_pending;

  flag_register_unit #(.FLAG_W(FW), .COMMIT_DEPTH(D)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flag_set_input  (flag_set_input),
    .flag_write_en   (flag_write_en),
    .flag_mask       (flag_mask),
    .stall           (stall),
    .flush           (flush),
    .irq_save        (irq_save),
    .irq_restore     (irq_restore),
    .cond_code       (cond_code),
    .flags_committed (flags_committed),
    .flags_forwarded (flags_forwarded),
    .cond_true       (cond_true),
    .flags_pending   (flags_pending)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       we;
    logic [3:0] fl;
    logic [3:0] mk;
    logic       st, fu, sv, rs;
    logic [2:0] cc;
    logic [3:0] e_fwd;
    logic       e_ct, e_pend;
    logic [3:0] e_comm;
  } vec_t;

  vec_t tbl[$];

  // Reference model: each accepted write is an item with edges left before it commits.
  typedef struct {
    logic [3:0] m;
    logic [3:0] f;
    int         rem;
  } mitem_t;

  mitem_t     mq[$];
  logic [3:0] m_comm;
  logic [3:0] m_shadow;

  function automatic vec_t v(input logic we, input logic [3:0] fl, input logic [3:0] mk,
                             input logic st, input logic fu, input logic sv, input logic rs,
                             input logic [2:0] cc, input logic [3:0] ef, input logic ec,
                             input logic ep, input logic [3:0] em);
    vec_t r;
    r.we = we; r.fl = fl; r.mk = mk; r.st = st; r.fu = fu; r.sv = sv; r.rs = rs; r.cc = cc;
    r.e_fwd = ef; r.e_ct = ec; r.e_pend = ep; r.e_comm = em;
    return r;
  endfunction

  function automatic logic [3:0] overlay(input logic [3:0] base, input logic [3:0] f, input logic [3:0] m);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = m[b] ? f[b] : base[b];
    return r;
  endfunction

  function automatic logic [3:0] model_fwd(input logic we, input logic [3:0] fl, input logic [3:0] mk, input logic fu);
    logic [3:0] r;
    r = m_comm;
    for (int i = 0; i < mq.size(); i++) r = overlay(r, mq[i].f, mq[i].m);
    if (we && !fu) r = overlay(r, fl, mk);
    return r;
  endfunction

  function automatic logic model_cond(input logic [2:0] cc, input logic [3:0] f);
    logic z, s, c, o;
    z = f[3]; s = f[2]; c = f[1]; o = f[0];
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return s;
      3'd4: return !s;
      3'd5: return c;
      3'd6: return o;
      default: return s != o;
    endcase
  endfunction

  task automatic model_reset();
    m_comm = 4'b0000;
    m_shadow = 4'b0000;
    mq.delete();
  endtask

  task automatic model_edge(input logic we, input logic [3:0] fl, input logic [3:0] mk,
                            input logic st, input logic fu, input logic sv, input logic rs);
    logic [3:0] nc;
    mitem_t     it;
    nc = m_comm;
    if (!st) begin
      if (mq.size() > 0 && mq[0].rem == 0) begin
        nc = overlay(nc, mq[0].f, mq[0].m);
        void'(mq.pop_front());
      end
      for (int i = 0; i < mq.size(); i++) mq[i].rem = mq[i].rem - 1;
    end
    if (fu) mq.delete();
    else if (!st && we) begin
      it.m = mk; it.f = fl; it.rem = D - 1;
      mq.push_back(it);
    end
    if (rs) m_comm = m_shadow;
    else begin
      m_comm = nc;
      if (sv) m_shadow = nc;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] fl, input logic [3:0] mk,
                       input logic st, input logic fu, input logic sv, input logic rs,
                       input logic [2:0] cc);
    @(negedge clk);
    flag_write_en = we; flag_set_input = fl; flag_mask = mk;
    stall = st; flush = fu; irq_save = sv; irq_restore = rs; cond_code = cc;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    flag_write_en = 1'b0; flag_set_input = '0; flag_mask = '0;
    stall = 1'b0; flush = 1'b0; irq_save = 1'b0; irq_restore = 1'b0; cond_code = 3'd0;

    //          we fl       mk       st fu sv rs cc     fwd      ct pend comm
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0000, 1, 0, 4'b0000));
    tbl.push_back(v(1, 4'b1010, 4'b1111, 0, 0, 0, 0, 3'd1, 4'b1010, 1, 0, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd2, 4'b1010, 0, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b1010, 1, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd3, 4'b1010, 0, 0, 4'b1010));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b1111, 1, 0, 4'b1010));
    tbl.push_back(v(1, 4'b0000, 4'b0010, 0, 0, 0, 0, 3'd5, 4'b1101, 0, 1, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd5, 4'b1101, 0, 1, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd4, 4'b1101, 0, 1, 4'b1111));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd1, 4'b1101, 1, 0, 4'b1101));
    tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b0000, 1, 0, 4'b1101));
    tbl.push_back(v(1, 4'b1000, 4'b1000, 0, 0, 0, 0, 3'd1, 4'b1000, 1, 1, 4'b1101));
    tbl.push_back(v(1, 4'b0001, 4'b0001, 0, 0, 0, 0, 3'd6, 4'b1001, 1, 1, 4'b1101));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd1, 4'b1001, 1, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd6, 4'b1001, 1, 1, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd7, 4'b1001, 1, 0, 4'b1001));
    tbl.push_back(v(1, 4'b0100, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b0100, 1, 0, 4'b1001));
    tbl.push_back(v(1, 4'b0011, 4'b1111, 1, 0, 0, 0, 3'd3, 4'b0011, 0, 1, 4'b1001));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 3'd3, 4'b0100, 1, 1, 4'b1001));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 3'd0, 4'b0100, 1, 1, 4'b1001));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0100, 1, 1, 4'b1001));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0100, 1, 1, 4'b1001));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd3, 4'b0100, 1, 0, 4'b0100));
    tbl.push_back(v(1, 4'b0000, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b0000, 1, 0, 4'b0100));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0000, 1, 1, 4'b0100));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0000, 1, 1, 4'b0100));
    tbl.push_back(v(1, 4'b0100, 4'b0100, 0, 0, 0, 0, 3'd3, 4'b0100, 1, 0, 4'b0000));
    tbl.push_back(v(1, 4'b0010, 4'b0010, 0, 0, 0, 0, 3'd5, 4'b0110, 1, 1, 4'b0000));
    tbl.push_back(v(1, 4'b1000, 4'b1000, 0, 1, 0, 0, 3'd1, 4'b0110, 0, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd3, 4'b0100, 1, 0, 4'b0100));
    tbl.push_back(v(1, 4'b0110, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b0110, 1, 0, 4'b0100));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0110, 1, 1, 4'b0100));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 3'd0, 4'b0110, 1, 1, 4'b0100));
    tbl.push_back(v(1, 4'b0001, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b0001, 1, 0, 4'b0110));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0001, 1, 1, 4'b0110));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0001, 1, 1, 4'b0110));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 1, 1, 3'd6, 4'b0001, 1, 0, 4'b0001));
    tbl.push_back(v(1, 4'b0011, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b0011, 1, 0, 4'b0110));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0011, 1, 1, 4'b0110));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 4'b0011, 1, 1, 4'b0110));
    tbl.push_back(v(1, 4'b1111, 4'b1111, 0, 0, 0, 0, 3'd0, 4'b1111, 1, 0, 4'b0011));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 1, 0, 1, 3'd1, 4'b1111, 1, 1, 4'b0011));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd1, 4'b0110, 0, 0, 4'b0110));

    #12;
    chk("reset_committed", flags_committed, 4'b0000);
    chk("reset_pending", {3'b000, flags_pending}, 4'b0000);
    chk("reset_forwarded", flags_forwarded, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].we, tbl[r].fl, tbl[r].mk, tbl[r].st, tbl[r].fu, tbl[r].sv, tbl[r].rs, tbl[r].cc);
      chk($sformatf("row%0d_fwd", r), flags_forwarded, tbl[r].e_fwd);
      chk($sformatf("row%0d_cond", r), {3'b000, cond_true}, {3'b000, tbl[r].e_ct});
      chk($sformatf("row%0d_pend", r), {3'b000, flags_pending}, {3'b000, tbl[r].e_pend});
      chk($sformatf("row%0d_comm", r), flags_committed, tbl[r].e_comm);
      @(posedge clk);
    end

    // Reset mid-operation: two writes in flight, committed and shadow hold 0110.
    drive(1, 4'b0101, 4'b1111, 0, 0, 0, 0, 3'd0);
    @(posedge clk);
    drive(1, 4'b1010, 4'b1111, 0, 0, 0, 0, 3'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    flag_write_en = 1'b0;
    #1;
    chk("midreset_committed", flags_committed, 4'b0000);
    chk("midreset_pending", {3'b000, flags_pending}, 4'b0000);
    chk("midreset_forwarded", flags_forwarded, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 4'b0000, 4'b0000, 0, 0, 0, 1, 3'd0);
    @(posedge clk);
    drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0);
    chk("shadow_cleared_by_reset", flags_committed, 4'b0000);
    chk("entries_cleared_by_reset", {3'b000, flags_pending}, 4'b0000);
    @(posedge clk);
    model_reset();

    for (int c = 0; c < 600; c++) begin
      logic       we, st, fu, sv, rs;
      logic [3:0] fl, mk, ef;
      logic [2:0] cc;
      we = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 9) < 2);
      fu = ($urandom_range(0, 24) < 2);
      sv = ($urandom_range(0, 9) < 1);
      rs = ($urandom_range(0, 19) < 1);
      fl = 4'($urandom);
      mk = 4'($urandom);
      cc = 3'($urandom);
      drive(we, fl, mk, st, fu, sv, rs, cc);
      ef = model_fwd(we, fl, mk, fu);
      chk($sformatf("rnd%0d_fwd", c), flags_forwarded, ef);
      chk($sformatf("rnd%0d_cond", c), {3'b000, cond_true}, {3'b000, model_cond(cc, ef)});
      chk($sformatf("rnd%0d_pend", c), {3'b000, flags_pending}, {3'b000, mq.size() > 0});
      chk($sformatf("rnd%0d_comm", c), flags_committed, m_comm);
      @(posedge clk);
      model_edge(we, fl, mk, st, fu, sv, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_register_unit.md
Name: flag_register_unit

Overview:
Status-flag stage fed directly by the flag unit's {zero,sign,carry,overflow} vector. It carries per-instruction flag writes down the pipeline from EX to commit and holds the architectural flag register. It forwards the youngest in-flight flag view to branch-condition evaluation and supports interrupt save/restore through a shadow copy.

Parameters:
FLAG_W, 4, flag vector width; bit order {zero,sign,carry,overflow}, MSB first
COMMIT_DEPTH, 2, number of in-flight entries between EX capture and commit; legal range 1..4

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flag_set_input  input  FLAG_W  flags computed for the current EX instruction
flag_write_en  input  1  current EX instruction writes flags
flag_mask  input  FLAG_W  per-flag update enable for the current EX instruction
stall  input  1  freeze in-flight entries and commit
flush  input  1  kill all uncommitted entries, including this cycle's EX input
irq_save  input  1  copy architectural flags to the shadow register
irq_restore  input  1  copy the shadow register to the architectural flags
cond_code  input  3  branch condition select
flags_committed  output  FLAG_W  architectural flag register
flags_forwarded  output  FLAG_W  youngest flag view, combinational
cond_true  output  1  cond_code evaluated on flags_forwarded, combinational
flags_pending  output  1  at least one valid uncommitted entry

Behaviour:
- Reset, asynchronous with reset_n=0: committed=0, shadow=0, all entry valid bits=0. Outputs: flags_committed=0, flags_pending=0, flags_forwarded=0 while flag_write_en=0.
- Entry format is {valid, mask[FLAG_W], flags[FLAG_W]}. Entries are indexed 0 (youngest) to COMMIT_DEPTH-1 (oldest).
- Per-edge priority: flush > stall > normal.
- Normal edge (stall=0, flush=0):
  - entry0 <= {flag_write_en, flag_mask, flag_set_input}.
  - entry[i] <= entry[i-1].
  - If the oldest entry is valid, committed <= (committed & ~mask) | (flags & mask).
- Stall edge (stall=1, flush=0): all entries hold, committed holds, and the current input is dropped. Upstream must re-present the input after the stall.
- Flush edge (flush=1): all entry valid bits <= 0, and the current input is not captured. Commit of the oldest entry still happens that edge if it is valid and stall=0. Committed is never rolled back.
- Latency: an input accepted at edge N reaches committed at edge N+COMMIT_DEPTH, provided no stall occurs; each stall cycle adds one cycle.
- irq_save: shadow <= the committed value that results from this edge, i.e. including any same-edge commit.
- irq_restore: committed <= shadow. Restore overrides a same-edge commit. Restore does not clear entries; the controller asserts flush alongside it.
- irq_save and irq_restore together: restore wins, and shadow is unchanged.
- flags_forwarded: start from committed. Overlay each valid entry with its mask, from oldest to youngest. Then overlay the current input if flag_write_en=1 and flush=0. The overlay ignores stall.
- cond_code mapping, on flags_forwarded (z,s,c,v):
  - 0 = always 1
  - 1 = z
  - 2 = ~z
  - 3 = s
  - 4 = ~s
  - 5 = c
  - 6 = v
  - 7 = (s ^ v), signed less-than
- flags_pending = OR of entry valid bits; registered state only, not the current input.
- A mask of 0 with write_en=1 occupies a slot but changes nothing.
- A reset mid-operation discards all in-flight entries and the shadow.

Test Plan:
- Reset, then one write with flags=4'b1010, mask=4'b1111, write_en=1 at edge 1 (D=2): flags_forwarded=1010 in the same cycle; flags_pending=1 after edges 1–2; flags_committed=1010 after edge 3; flags_pending=0 after edge 3.
- Partial mask: committed=1111, write flags=0000 mask=0010: committed becomes 1101 at commit, and forwarded shows 1101 from presentation onward.
- Back-to-back writes 1000/m=1000 then 0001/m=0001 from committed=0000: forwarded=1001 while both are in flight; cond_code=1 gives cond_true=1 and cond_code=6 gives 1; final committed=1001.
- Stall for 3 cycles with one entry in flight: committed is unchanged during the stall; the commit edge shifts by 3; the input presented during the stall is not captured.
- Flush with two valid entries (0100, 0010 over committed=0000): the oldest commits on that edge if not stalled, the younger is dropped, and flags_pending=0 afterwards.
- irq_save with committed=0110, then flags overwritten to 0001, then irq_restore+flush: committed=0110 and flags_pending=0. Save and restore on the same edge leaves shadow unchanged.
